// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared widths and the arbiter state encoding for the CPU
//                memory-port slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Shared-port arbiter states; the two BUSY states own the port.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arbState_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Arbitrates one shared memory port between the instruction
//                fetch (IF) and data memory (MEM) stages. Data wins ties,
//                each stage is served once per pipeline advance, and the
//                pipeline is held by stall_all until every pending access
//                has been served. Fetch redirects drop stale fetch data.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,

    input  logic              dm_req,
    input  logic              dm_write,
    input  logic [STRB_W-1:0] dm_wstrb,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,

    output logic              stall_all,

    output logic              mem_req,
    output logic              mem_write,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arbState_t         r_state;
    arbState_t         w_stateNext;

    logic              r_ifServed;
    logic              r_dmServed;
    logic              r_ifKill;

    logic              r_memWrite;
    logic [STRB_W-1:0] r_memWstrb;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic [DATA_W-1:0] r_ifRdata;
    logic [DATA_W-1:0] r_dmRdata;

    logic              w_ifPending;
    logic              w_dmPending;
    logic              w_advance;
    logic              w_grantDm;
    logic              w_grantIf;
    logic              w_ifDone;
    logic              w_dmDone;
    logic              w_ifDrop;

    // A stage is pending when it asks for an access it has not yet received
    // during the current pipeline step.
    assign w_ifPending = if_req && !r_ifServed;
    assign w_dmPending = dm_req && !r_dmServed;

    assign if_stall    = w_ifPending;
    assign dm_stall    = w_dmPending;
    assign stall_all   = w_ifPending || w_dmPending;
    assign w_advance   = !(w_ifPending || w_dmPending);

    // Grants happen only from IDLE; data access has priority over fetch.
    assign w_grantDm   = (r_state == IDLE) && w_dmPending;
    assign w_grantIf   = (r_state == IDLE) && !w_dmPending && w_ifPending;

    // Completion is only meaningful while a transaction owns the port, so a
    // stray mem_ready in IDLE has no effect.
    assign w_ifDone    = (r_state == IF_BUSY) && mem_ready;
    assign w_dmDone    = (r_state == DM_BUSY) && mem_ready;

    // A redirect seen earlier in the fetch, or in its completion cycle,
    // makes the returned word stale.
    assign w_ifDrop    = r_ifKill || if_flush;

    assign mem_req     = (r_state != IDLE);
    assign mem_write   = r_memWrite;
    assign mem_wstrb   = r_memWstrb;
    assign mem_addr    = r_memAddr;
    assign mem_wdata   = r_memWdata;
    assign if_rdata    = r_ifRdata;
    assign dm_rdata    = r_dmRdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: arbitrate in IDLE, wait for completion when busy.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (w_dmPending) begin
                    w_stateNext = DM_BUSY;
                end else if (w_ifPending) begin
                    w_stateNext = IF_BUSY;
                end
            end
            IF_BUSY: begin
                if (mem_ready) begin
                    w_stateNext = IDLE;
                end
            end
            DM_BUSY: begin
                if (mem_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Port request fields are captured at grant and held until the next
    // grant, so they stay stable for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_memWrite <= 1'b0;
            r_memWstrb <= '0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
        end else if (w_grantDm) begin
            r_memWrite <= dm_write;
            r_memWstrb <= dm_wstrb;
            r_memAddr  <= dm_addr;
            r_memWdata <= dm_wdata;
        end else if (w_grantIf) begin
            r_memWrite <= 1'b0;
            r_memWstrb <= '0;
            r_memAddr  <= if_addr;
            r_memWdata <= '0;
        end
    end

    // Served and kill flags: completion marks a stage served, a pipeline
    // advance starts a fresh step, a redirect invalidates the fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifServed <= 1'b0;
            r_dmServed <= 1'b0;
            r_ifKill   <= 1'b0;
        end else begin
            if (w_ifDone && !w_ifDrop) begin
                r_ifServed <= 1'b1;
            end else if (w_advance || if_flush) begin
                r_ifServed <= 1'b0;
            end

            if (w_dmDone) begin
                r_dmServed <= 1'b1;
            end else if (w_advance) begin
                r_dmServed <= 1'b0;
            end

            if (r_state != IF_BUSY) begin
                r_ifKill <= 1'b0;
            end else if (mem_ready) begin
                r_ifKill <= 1'b0;
            end else if (if_flush) begin
                r_ifKill <= 1'b1;
            end
        end
    end

    // Read-data capture; each register holds until its next valid capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifRdata <= '0;
            r_dmRdata <= '0;
        end else begin
            if (w_ifDone && !w_ifDrop) begin
                r_ifRdata <= mem_rdata;
            end
            if (w_dmDone) begin
                r_dmRdata <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter: directed latency,
//                collision, wait-state, flush and reset scenarios followed by
//                randomized pipeline steps against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    import cpu_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;
    logic              dm_req;
    logic              dm_write;
    logic [STRB_W-1:0] dm_wstrb;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_stall;
    logic              stall_all;
    logic              mem_req;
    logic              mem_write;
    logic [STRB_W-1:0] mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter u_dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_write  (dm_write),
        .dm_wstrb  (dm_wstrb),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_stall  (dm_stall),
        .stall_all (stall_all),
        .mem_req   (mem_req),
        .mem_write (mem_write),
        .mem_wstrb (mem_wstrb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pipeline step: hold the requests until stall_all drops, acting as
    // the memory with the given wait states, then check that the port saw
    // exactly the data access (if any) followed by the fetch (if any).
    task automatic runStep(input logic ifReq, input logic [31:0] ifAddr,
                           input logic dmReq, input logic dmWrite,
                           input logic [3:0] dmStrb, input logic [31:0] dmAddr,
                           input logic [31:0] dmWdata,
                           input int waitFirst, input int waitSecond);
        logic [31:0] txAddr  [4];
        logic [31:0] txWdata [4];
        logic [31:0] txRdata [4];
        logic        txWrite [4];
        logic [3:0]  txStrb  [4];
        logic [68:0] latched;
        logic        inTx;
        int          waitCnt;
        int          nTx;
        int          nExp;
        int          cyc;
        int          idx;
        bit          done;

        if_req   = ifReq;
        if_addr  = ifAddr;
        dm_req   = dmReq;
        dm_write = dmWrite;
        dm_wstrb = dmStrb;
        dm_addr  = dmAddr;
        dm_wdata = dmWdata;
        nTx      = 0;
        inTx     = 1'b0;
        waitCnt  = 0;
        cyc      = 0;
        done     = 1'b0;
        latched  = '0;

        while (!done) begin
            if (mem_req) begin
                if (!inTx) begin
                    inTx    = 1'b1;
                    waitCnt = 0;
                    latched = {mem_addr, mem_write, mem_wstrb, mem_wdata};
                end
                mem_ready = (waitCnt >= ((nTx == 0) ? waitFirst : waitSecond));
            end else begin
                mem_ready = ($urandom_range(7) == 0);
            end
            mem_rdata = $urandom;
            #1;
            if (mem_req && mem_ready) begin
                checkEq("stable", {mem_addr, mem_write, mem_wstrb, mem_wdata}, latched);
                if (nTx < 4) begin
                    txAddr[nTx]  = mem_addr;
                    txWrite[nTx] = mem_write;
                    txStrb[nTx]  = mem_wstrb;
                    txWdata[nTx] = mem_wdata;
                    txRdata[nTx] = mem_rdata;
                end
                nTx++;
                inTx = 1'b0;
            end else if (mem_req) begin
                waitCnt++;
            end
            if (!stall_all) begin
                done = 1'b1;
            end else if (cyc >= 60) begin
                checkEq("step_timeout", 1, 0);
                done = 1'b1;
            end else begin
                cyc++;
                tick();
            end
        end

        nExp = int'(ifReq) + int'(dmReq);
        checkEq("tx_count", nTx, nExp);
        if (dmReq && nTx >= 1) begin
            checkEq("dm_addr", txAddr[0], dmAddr);
            checkEq("dm_fields", {txWrite[0], txStrb[0], txWdata[0]}, {dmWrite, dmStrb, dmWdata});
            checkEq("dm_rdata", dm_rdata, txRdata[0]);
        end
        if (ifReq && nTx == nExp) begin
            idx = nExp - 1;
            checkEq("if_addr", txAddr[idx], ifAddr);
            checkEq("if_fields", {txWrite[idx], txStrb[idx]}, 5'b0);
            checkEq("if_rdata", if_rdata, txRdata[idx]);
        end
        tick();
        mem_ready = 1'b0;
    endtask

    // Stimulus and checking.
    initial begin
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        if_flush  = 1'b0;
        dm_req    = 1'b1;
        dm_write  = 1'b0;
        dm_wstrb  = '0;
        dm_addr   = 32'h0000_0900;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        // Reset state, with a request present during reset.
        tick();
        tick();
        #1;
        checkEq("rst_mem_req", mem_req, 1'b0);
        checkEq("rst_mem_fields", {mem_addr, mem_write, mem_wstrb, mem_wdata}, 69'h0);
        checkEq("rst_rdata", {if_rdata, dm_rdata}, 64'h0);
        checkEq("rst_dm_stall", dm_stall, 1'b1);
        checkEq("rst_stall_all", stall_all, 1'b1);
        dm_req  = 1'b0;
        dm_addr = '0;
        tick();
        rst = 1'b0;

        // Fetch only, zero wait states.
        tick();
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        #1;
        checkEq("f0_if_stall", if_stall, 1'b1);
        checkEq("f0_mem_req", mem_req, 1'b0);
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0013;
        #1;
        checkEq("f1_mem_req", mem_req, 1'b1);
        checkEq("f1_mem_addr", mem_addr, 32'h0000_0040);
        checkEq("f1_rd_fields", {mem_write, mem_wstrb}, 5'b0);
        tick();
        mem_ready = 1'b0;
        #1;
        checkEq("f2_mem_req", mem_req, 1'b0);
        checkEq("f2_if_rdata", if_rdata, 32'h0000_0013);
        checkEq("f2_if_stall", if_stall, 1'b0);
        tick();
        if_req = 1'b0;
        #1;
        checkEq("f3_mem_req", mem_req, 1'b0);

        // Collision: data first, then fetch.
        tick();
        if_req   = 1'b1;
        if_addr  = 32'h0000_0200;
        dm_req   = 1'b1;
        dm_write = 1'b0;
        dm_addr  = 32'h0000_0100;
        #1;
        checkEq("c0_stall_all", stall_all, 1'b1);
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'hAAAA_0001;
        #1;
        checkEq("c1_mem_req", mem_req, 1'b1);
        checkEq("c1_mem_addr", mem_addr, 32'h0000_0100);
        tick();
        mem_ready = 1'b0;
        #1;
        checkEq("c2_stalls", {mem_req, dm_stall, if_stall, stall_all}, 4'b0011);
        checkEq("c2_dm_rdata", dm_rdata, 32'hAAAA_0001);
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        #1;
        checkEq("c3_mem_req", mem_req, 1'b1);
        checkEq("c3_mem_addr", mem_addr, 32'h0000_0200);
        tick();
        mem_ready = 1'b0;
        #1;
        checkEq("c4_stall_all", stall_all, 1'b0);
        checkEq("c4_if_rdata", if_rdata, 32'h1234_5678);
        tick();
        if_req = 1'b0;
        dm_req = 1'b0;
        #1;
        checkEq("c5_mem_req", mem_req, 1'b0);
        tick();
        checkEq("c6_mem_req", mem_req, 1'b0);

        // Store with three wait states.
        dm_req   = 1'b1;
        dm_write = 1'b1;
        dm_wstrb = 4'b0011;
        dm_wdata = 32'hDEAD_BEEF;
        dm_addr  = 32'h0000_0300;
        #1;
        checkEq("s0_dm_stall", dm_stall, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            mem_ready = (i == 3);
            mem_rdata = 32'hCAFE_0000;
            #1;
            checkEq("s_mem_req", mem_req, 1'b1);
            checkEq("s_mem_fields", {mem_addr, mem_write, mem_wstrb, mem_wdata},
                    {32'h0000_0300, 1'b1, 4'b0011, 32'hDEAD_BEEF});
            checkEq("s_dm_stall", dm_stall, 1'b1);
        end
        tick();
        mem_ready = 1'b0;
        #1;
        checkEq("s5_dm_stall", dm_stall, 1'b0);
        checkEq("s5_mem_req", mem_req, 1'b0);
        checkEq("s5_dm_rdata", dm_rdata, 32'hCAFE_0000);
        tick();
        dm_req   = 1'b0;
        dm_write = 1'b0;
        dm_wstrb = '0;

        // Flush mid-fetch, then flush coinciding with completion.
        tick();
        if_req  = 1'b1;
        if_addr = 32'h0000_0400;
        tick();
        if_flush = 1'b1;
        #1;
        checkEq("k1_mem_req", mem_req, 1'b1);
        tick();
        if_flush  = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        checkEq("k2_mem_req", mem_req, 1'b1);
        tick();
        mem_ready = 1'b0;
        #1;
        checkEq("k3_if_stall", if_stall, 1'b1);
        checkEq("k3_if_rdata", if_rdata, 32'h1234_5678);
        checkEq("k3_mem_req", mem_req, 1'b0);
        tick();
        #1;
        checkEq("k4_mem_req", mem_req, 1'b1);
        checkEq("k4_mem_addr", mem_addr, 32'h0000_0400);
        if_flush  = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
        tick();
        if_flush  = 1'b0;
        mem_ready = 1'b0;
        #1;
        checkEq("k5_if_stall", if_stall, 1'b1);
        checkEq("k5_if_rdata", if_rdata, 32'h1234_5678);
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        #1;
        checkEq("k6_mem_req", mem_req, 1'b1);
        tick();
        mem_ready = 1'b0;
        #1;
        checkEq("k7_if_stall", if_stall, 1'b0);
        checkEq("k7_if_rdata", if_rdata, 32'h5555_AAAA);
        tick();
        if_req = 1'b0;

        // Reset in the middle of a data transaction; a late ready is ignored.
        tick();
        dm_req   = 1'b1;
        dm_write = 1'b1;
        dm_wstrb = 4'hF;
        dm_wdata = 32'h0000_0011;
        dm_addr  = 32'h0000_0500;
        tick();
        #1;
        checkEq("r1_mem_req", mem_req, 1'b1);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        dm_req   = 1'b0;
        dm_write = 1'b0;
        #1;
        checkEq("r2_mem_req", mem_req, 1'b0);
        checkEq("r2_mem_fields", {mem_addr, mem_write, mem_wstrb, mem_wdata}, 69'h0);
        checkEq("r2_rdata", {if_rdata, dm_rdata}, 64'h0);
        checkEq("r2_dm_stall", dm_stall, 1'b0);
        tick();
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0077;
        #1;
        checkEq("r4_mem_req", mem_req, 1'b0);
        tick();
        mem_ready = 1'b0;
        #1;
        checkEq("r5_mem_req", mem_req, 1'b0);
        checkEq("r5_dm_rdata", dm_rdata, 32'h0);
        checkEq("r5_stall_all", stall_all, 1'b0);
        tick();

        // Data request held across a slow fetch.
        runStep(1'b1, 32'h0000_0600, 1'b1, 1'b0, 4'h0, 32'h0000_0700, 32'h0, 0, 5);

        // Randomized pipeline steps.
        for (int s = 0; s < 150; s++) begin
            runStep($urandom_range(3) != 0, $urandom & 32'hFFFF_FFFC,
                    $urandom_range(1) == 1, $urandom_range(1) == 1,
                    4'($urandom_range(15)), $urandom & 32'hFFFF_FFFC, $urandom,
                    $urandom_range(3), $urandom_range(3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "time limit reached");
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The clock SHALL be clk, the reset SHALL be rst, and there SHALL be one clock with a synchronous, active-high reset.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
  clk  in  1  system clock
  rst  in  1  synchronous active-high reset
  if_req  in  1  IF stage needs an instruction word
  if_addr  in  32  fetch address
  if_flush  in  1  fetch redirect; the in-flight fetch is stale
  if_rdata  out  32  captured instruction word
  if_stall  out  1  IF access not yet served
  dm_req  in  1  MEM stage needs a data access
  dm_write  in  1  1 = store, 0 = load
  dm_wstrb  in  4  byte enables for a store
  dm_addr  in  32  data address
  dm_wdata  in  32  store data
  dm_rdata  out  32  captured load data
  dm_stall  out  1  data access not yet served
  stall_all  out  1  if_stall | dm_stall; freezes PC and all pipeline registers
  mem_req  out  1  shared port request
  mem_write  out  1  shared port write
  mem_wstrb  out  4  shared port byte enables
  mem_addr  out  32  shared port address
  mem_wdata  out  32  shared port write data
  mem_rdata  in  32  shared port read data
  mem_ready  in  1  shared port completion; high for one cycle per transaction

Function
REQ-003 The FSM SHALL have the states IDLE, IF_BUSY and DM_BUSY.
REQ-004 In IDLE, a pending data request (dm_req && !dm_served) SHALL win arbitration and cause a transition to DM_BUSY.
REQ-005 In IDLE, when no data request is pending, a pending fetch (if_req && !if_served) SHALL cause a transition to IF_BUSY.
REQ-006 In IDLE with neither request pending, the FSM SHALL stay in IDLE.
REQ-007 At grant, the requester's address, write, wstrb and wdata SHALL be registered.
REQ-008 During a fetch, mem_write SHALL be 0 and mem_wstrb SHALL be 4'b0000.
REQ-009 mem_req SHALL be 1 exactly while the FSM is in a BUSY state.
REQ-010 All mem_* outputs SHALL be stable from grant until mem_ready is sampled high; a transaction SHALL never be aborted.
REQ-011 When mem_ready is high in BUSY:
  - mem_rdata SHALL be captured into if_rdata or dm_rdata;
  - the matching served flag SHALL be set;
  - the FSM SHALL return to IDLE.
  if_rdata and dm_rdata SHALL hold their values until the next capture.
REQ-012 The stall outputs SHALL be purely combinational: if_stall = if_req && !if_served, and dm_stall = dm_req && !dm_served.
REQ-013 Pipeline advance SHALL be !stall_all; in any advance cycle, both served flags SHALL clear on the next edge.
REQ-014 With zero wait states, latency SHALL be: request seen in IDLE in cycle 0, BUSY with mem_ready in cycle 1, and the stall low in cycle 2.
REQ-015 Each additional cycle without mem_ready SHALL add one cycle of latency.
REQ-016 If if_req and dm_req are both pending, the data access SHALL be served first, then the fetch; stall_all SHALL stay high until both are served.
REQ-017 A served requester SHALL NOT be re-granted until the served flags clear, so a request held during stall SHALL cause exactly one transaction.
REQ-018 if_flush in IDLE or in DM_BUSY SHALL clear if_served on the next edge.
REQ-019 if_flush in IF_BUSY SHALL set a kill flag; at completion the data SHALL be dropped, if_served SHALL stay 0 and the fetch SHALL be re-arbitrated.
REQ-020 if_flush and completion in the same cycle SHALL behave as a flush (data dropped).
REQ-021 A request deasserted while its transaction is in flight SHALL still complete on the port, and its served flag SHALL still be set.

Reset
REQ-022 While rst is high, the next edge SHALL put the FSM in IDLE and clear the served and kill flags.
REQ-023 On reset, mem_req, mem_write, mem_wstrb, mem_addr, mem_wdata, if_rdata and dm_rdata SHALL be 0.
REQ-024 Reset mid-transaction SHALL drop mem_req on the next edge; a late mem_ready arriving in IDLE SHALL be ignored.
REQ-025 The stall outputs SHALL follow REQ-012 from the registers, so a request present during reset SHALL read as stalled.

Structure
REQ-026 The state enum and localparams ADDR_W=32, DATA_W=32 and STRB_W=4 SHALL live in shared package cpu_pkg.
REQ-027 The block SHALL be a single module with no sub-module; the arbitration and FSM are too small to split.

Verification
REQ-028 Fetch only, zero wait: if_req=1, if_addr=0x0000_0040, mem_ready in cycle 1, mem_rdata=0x0000_0013 -> mem_req high for 1 cycle, if_rdata=0x13 and if_stall=0 in cycle 2.
REQ-029 Collision: if_req=1, dm_req=1, dm_write=0, dm_addr=0x100 -> first mem_addr=0x100, second mem_addr=if_addr, stall_all low only after both, each served exactly once.
REQ-030 Store with 3 wait states: dm_write=1, dm_wstrb=4'b0011, dm_wdata=0xDEAD_BEEF -> mem_* stable for 4 cycles, dm_stall low 1 cycle after mem_ready.
REQ-031 Flush mid-fetch: if_flush pulsed in IF_BUSY, completion data 0xFFFF_FFFF -> if_rdata unchanged, a second fetch issued, if_stall high until it completes.
REQ-032 Reset mid-DM_BUSY: rst high 1 cycle -> mem_req=0 next cycle, state IDLE, a mem_ready 2 cycles later ignored, outputs at reset values.
REQ-033 Held request: dm_req held high across 5 stalled cycles with a slow fetch -> exactly one data transaction on the port.
